// File: rtl/vga_timing_core.sv
// vga_timing_core: pixel-rate divider, h/v coordinate counters and registered
// colour/sync outputs with a fixed one-pixel latency behind the coordinate.
module vga_timing_core #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CLK_DIV   = 2,
   parameter int COLOR_W   = 4,
   parameter int CNT_W     = 11
) (
   input  logic               iclock,
   input  logic               ireset,
   input  logic               ienable,
   input  logic [COLOR_W-1:0] ipixel_r,
   input  logic [COLOR_W-1:0] ipixel_g,
   input  logic [COLOR_W-1:0] ipixel_b,
   output logic [CNT_W-1:0]   ohcount,
   output logic [CNT_W-1:0]   ovcount,
   output logic               oactive,
   output logic               oline_start,
   output logic               oframe_start,
   output logic [COLOR_W-1:0] ovga_r,
   output logic [COLOR_W-1:0] ovga_g,
   output logic [COLOR_W-1:0] ovga_b,
   output logic               ohsync,
   output logic               ovsync
);
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int VS_START = V_ACTIVE + V_FP;
   logic [3:0] div;
   logic       tick, h_last, v_last, hs_region, vs_region;
   assign tick      = ienable && (div == 4'(CLK_DIV - 1));
   assign h_last    = ohcount == CNT_W'(H_TOTAL - 1);
   assign v_last    = ovcount == CNT_W'(V_TOTAL - 1);
   assign oactive   = (ohcount < CNT_W'(H_ACTIVE)) && (ovcount < CNT_W'(V_ACTIVE));
   assign hs_region = (ohcount >= CNT_W'(HS_START)) && (ohcount < CNT_W'(HS_START + H_SYNC));
   assign vs_region = (ovcount >= CNT_W'(VS_START)) && (ovcount < CNT_W'(VS_START + V_SYNC));
   // Counters reset to the last pixel so the first tick lands on (0,0) with both strobes.
   always_ff @(posedge iclock or posedge ireset) begin
      if (ireset) begin
         div          <= '0;
         ohcount      <= CNT_W'(H_TOTAL - 1);
         ovcount      <= CNT_W'(V_TOTAL - 1);
         ovga_r       <= '0;
         ovga_g       <= '0;
         ovga_b       <= '0;
         ohsync       <= ~HSYNC_POL;
         ovsync       <= ~VSYNC_POL;
         oline_start  <= 1'b0;
         oframe_start <= 1'b0;
      end else begin
         oline_start  <= tick && h_last;
         oframe_start <= tick && h_last && v_last;
         if (ienable) div <= tick ? '0 : div + 4'd1;
         if (tick) begin
            ohcount <= h_last ? '0 : ohcount + CNT_W'(1);
            if (h_last) ovcount <= v_last ? '0 : ovcount + CNT_W'(1);
            ovga_r  <= oactive ? ipixel_r : '0;
            ovga_g  <= oactive ? ipixel_g : '0;
            ovga_b  <= oactive ? ipixel_b : '0;
            ohsync  <= hs_region ? HSYNC_POL : ~HSYNC_POL;
            ovsync  <= vs_region ? VSYNC_POL : ~VSYNC_POL;
         end
      end
   end
endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core: directed table, line/frame sweeps, async reset and random
// enable/pixel traffic checked against a pixel-position model.
module tb_vga_timing_core;
   logic        iclock, ireset, ienable;
   logic [3:0]  ipixel_r, ipixel_g, ipixel_b;
   logic [10:0] a_h, a_v, b_h, b_v;
   logic        a_act, a_ls, a_fs, a_hs, a_vs, b_act, b_ls, b_fs, b_hs, b_vs;
   logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
   int          checks = 0, failures = 0;
   int          n = 0;
   bit          en_last = 0;
   logic [11:0] pxa = '0, pxb = '0;
   typedef struct packed {
      logic [10:0] h, v;
      logic        act, ls, fs;
      logic [3:0]  r, g, b;
      logic        hs, vs;
   } exp_t;
   typedef struct {
      bit en;
      int cyc;
      int h, v;
      bit act, hs, ls, fs;
   } vec_t;
   vga_timing_core dut_a (
      .iclock(iclock), .ireset(ireset), .ienable(ienable),
      .ipixel_r(ipixel_r), .ipixel_g(ipixel_g), .ipixel_b(ipixel_b),
      .ohcount(a_h), .ovcount(a_v), .oactive(a_act),
      .oline_start(a_ls), .oframe_start(a_fs),
      .ovga_r(a_r), .ovga_g(a_g), .ovga_b(a_b), .ohsync(a_hs), .ovsync(a_vs)
   );
   // Full-width lines with a short frame so whole frames fit in the run.
   vga_timing_core #(
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1)
   ) dut_b (
      .iclock(iclock), .ireset(ireset), .ienable(ienable),
      .ipixel_r(ipixel_r), .ipixel_g(ipixel_g), .ipixel_b(ipixel_b),
      .ohcount(b_h), .ovcount(b_v), .oactive(b_act),
      .oline_start(b_ls), .oframe_start(b_fs),
      .ovga_r(b_r), .ovga_g(b_g), .ovga_b(b_b), .ohsync(b_hs), .ovsync(b_vs)
   );
   initial iclock = 1'b0;
   always #5 iclock = ~iclock;
   // Expected outputs after t pixel ticks: the coordinate is pixel t-1 of the
   // frame, colour and syncs belong to pixel t-2.
   function automatic exp_t model(int t, bit tk, logic [11:0] px, int va, int vf, int vs, int vb, bit hp, bit vp);
      exp_t e;
      int ht, tot, pos, prv, ph, pv;
      ht  = 800;
      tot = ht * (va + vf + vs + vb);
      pos = (t + tot - 1) % tot;
      prv = (t + tot - 2) % tot;
      ph  = prv % ht;
      pv  = prv / ht;
      e.h   = 11'(pos % ht);
      e.v   = 11'(pos / ht);
      e.act = (pos % ht < 640) && (pos / ht < va);
      e.ls  = tk && (pos % ht == 0);
      e.fs  = e.ls && (pos / ht == 0);
      {e.r, e.g, e.b} = (t > 0 && ph < 640 && pv < va) ? px : 12'h0;
      e.hs = (t > 0 && ph >= 656 && ph < 752) ? hp : ~hp;
      e.vs = (t > 0 && pv >= va + vf && pv < va + vf + vs) ? vp : ~vp;
      return e;
   endfunction
   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
      end
   endtask
   task automatic check_model();
      exp_t ga, gb;
      ga = {a_h, a_v, a_act, a_ls, a_fs, a_r, a_g, a_b, a_hs, a_vs};
      gb = {b_h, b_v, b_act, b_ls, b_fs, b_r, b_g, b_b, b_hs, b_vs};
      chk("model_a", 64'(ga), 64'(model(n / 2, en_last && (n % 2 == 0), pxa, 480, 10, 2, 33, 1'b0, 1'b0)));
      chk("model_b", 64'(gb), 64'(model(n, en_last, pxb, 4, 1, 2, 1, 1'b1, 1'b1)));
   endtask
   task automatic step(input bit en, input logic [11:0] px);
      ienable = en;
      {ipixel_r, ipixel_g, ipixel_b} = px;
      @(posedge iclock);
      if (en) begin
         n++;
         pxb = px;
         if (n % 2 == 0) pxa = px;
      end
      en_last = en;
      #1 check_model();
   endtask
   task automatic do_reset();
      ireset = 1'b1;
      #2;
      n = 0;
      en_last = 0;
      pxa = '0;
      pxb = '0;
      check_model();
      @(posedge iclock);
      #1 ireset = 1'b0;
   endtask
   vec_t tbl[11];
   int   per, lo, first, rf, vsc, vfirst, actc, hsc, a_fs_n, b_ls_n;
   initial begin
      tbl[0]  = '{1, 1,    799, 524, 0, 1, 0, 0};
      tbl[1]  = '{1, 1,    0,   0,   1, 1, 1, 1};
      tbl[2]  = '{1, 1,    0,   0,   1, 1, 0, 0};
      tbl[3]  = '{0, 37,   0,   0,   1, 1, 0, 0};
      tbl[4]  = '{1, 1,    1,   0,   1, 1, 0, 0};
      tbl[5]  = '{1, 1310, 656, 0,   0, 1, 0, 0};
      tbl[6]  = '{1, 2,    657, 0,   0, 0, 0, 0};
      tbl[7]  = '{1, 190,  752, 0,   0, 0, 0, 0};
      tbl[8]  = '{1, 2,    753, 0,   0, 1, 0, 0};
      tbl[9]  = '{1, 94,   0,   1,   1, 1, 1, 0};
      tbl[10] = '{1, 1,    0,   1,   1, 1, 0, 0};
      ireset = 1'b1;
      ienable = 1'b0;
      {ipixel_r, ipixel_g, ipixel_b} = 12'h0;
      do_reset();
      chk("rst_h", 64'(a_h), 64'(799));
      chk("rst_v", 64'(a_v), 64'(524));
      chk("rst_act", 64'(a_act), 64'(0));
      chk("rst_sync", 64'({a_hs, a_vs, b_hs, b_vs}), 64'(4'b1100));
      chk("rst_rgb", 64'({a_r, a_g, a_b}), 64'(0));
      for (int i = 0; i < 11; i++) begin
         for (int c = 0; c < tbl[i].cyc; c++) step(tbl[i].en, 12'($urandom));
         chk($sformatf("tbl%0d_h", i), 64'(a_h), 64'(tbl[i].h));
         chk($sformatf("tbl%0d_v", i), 64'(a_v), 64'(tbl[i].v));
         chk($sformatf("tbl%0d_act", i), 64'(a_act), 64'(tbl[i].act));
         chk($sformatf("tbl%0d_hs", i), 64'(a_hs), 64'(tbl[i].hs));
         chk($sformatf("tbl%0d_ls", i), 64'(a_ls), 64'(tbl[i].ls));
         chk($sformatf("tbl%0d_fs", i), 64'(a_fs), 64'(tbl[i].fs));
      end
      // One full line at CLK_DIV=2 with red held at full scale.
      per = 0;
      while (!a_ls && per < 4000) begin step(1'b1, 12'hF00); per++; end
      chk("a_ls_found", 64'(a_ls), 64'(1));
      per = 0; lo = 0; first = -1; rf = 0;
      do begin
         if (!a_hs) begin lo++; if (first < 0) first = int'(a_h) - 1; end
         if (a_r == 4'hF) rf++;
         step(1'b1, 12'hF00);
         per++;
      end while (!a_ls && per < 4000);
      chk("a_line_period", 64'(per), 64'(1600));
      chk("a_hsync_low_cycles", 64'(lo), 64'(192));
      chk("a_hsync_first_pixel", 64'(first), 64'(656));
      chk("a_red_cycles", 64'(rf), 64'(1280));
      // One full frame of the short-frame instance, CLK_DIV=1.
      do_reset();
      step(1'b1, 12'($urandom));
      chk("b_fs_first", 64'(b_fs), 64'(1));
      chk("a_fs_not_yet", 64'(a_fs), 64'(0));
      per = 0; vsc = 0; vfirst = -1; actc = 0; hsc = 0; a_fs_n = -1; b_ls_n = -1;
      do begin
         step(1'b1, 12'($urandom));
         per++;
         if (a_fs && a_fs_n < 0) a_fs_n = n;
         if (b_ls && b_ls_n < 0) b_ls_n = n;
         if (b_vs) begin vsc++; if (vfirst < 0) vfirst = int'(b_v); end
         if (b_act) actc++;
         if (b_hs) hsc++;
      end while (!b_fs && per < 8000);
      chk("a_fs_delay", 64'(a_fs_n - 1), 64'(1));
      chk("b_line_period", 64'(b_ls_n - 1), 64'(800));
      chk("b_frame_period", 64'(per), 64'(6400));
      chk("b_vsync_cycles", 64'(vsc), 64'(1600));
      chk("b_vsync_first_line", 64'(vfirst), 64'(5));
      chk("b_active_cycles", 64'(actc), 64'(2560));
      chk("b_hsync_cycles", 64'(hsc), 64'(768));
      // Reset in the middle of both hsync pulses releases them immediately.
      do_reset();
      repeat (1480) step(1'b1, 12'($urandom));
      chk("a_hs_pre_rst", 64'(a_hs), 64'(0));
      chk("b_hs_pre_rst", 64'(b_hs), 64'(1));
      ireset = 1'b1;
      #1;
      chk("a_hs_async_rst", 64'(a_hs), 64'(1));
      chk("b_hs_async_rst", 64'(b_hs), 64'(0));
      chk("a_h_async_rst", 64'(a_h), 64'(799));
      do_reset();
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 2999) == 0) do_reset();
         step($urandom_range(0, 3) != 0, 12'($urandom));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
